// File: rtl/mdu_iterative.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiplier and
// restoring divider sharing one 2*XLEN accumulator, with a sign-fixup stage.
module mdu_iterative #(
  parameter int XLEN       = 32,
  parameter int MUL_UNROLL = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in_x,
  input  logic [XLEN-1:0] in_y,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_UNROLL - 1);
  localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL_EXEC, DIV_EXEC, FIXUP, DONE} state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic                neg_x, neg_y, bypass;
  logic [XLEN-1:0]     mag_x, mag_y;
  logic [2*XLEN-1:0]   acc;
  logic [CW-1:0]       cnt;

  // Request decode: signedness, magnitudes and the two divide bypass cases
  logic            x_signed, y_signed, sx, sy, div_zero, div_ovf;
  logic [XLEN-1:0] abs_x, abs_y;

  assign x_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                    (op == 3'b100) || (op == 3'b110);
  assign y_signed = (op == 3'b000) || (op == 3'b001) ||
                    (op == 3'b100) || (op == 3'b110);
  assign sx       = x_signed && in_x[XLEN-1];
  assign sy       = y_signed && in_y[XLEN-1];
  assign abs_x    = sx ? -in_x : in_x;
  assign abs_y    = sy ? -in_y : in_y;
  assign div_zero = op[2] && (in_y == '0);
  assign div_ovf  = ((op == 3'b100) || (op == 3'b110)) &&
                    (in_x == SMIN) && (in_y == '1);

  // Multiply step: add multiplicand * low chunk into the high half, shift right
  logic [XLEN+MUL_UNROLL-1:0] mul_part, mul_sum;
  logic [2*XLEN-1:0]          mul_next;

  assign mul_part = {{MUL_UNROLL{1'b0}}, mag_x} *
                    {{XLEN{1'b0}}, acc[MUL_UNROLL-1:0]};
  assign mul_sum  = mul_part + {{MUL_UNROLL{1'b0}}, acc[2*XLEN-1:XLEN]};
  assign mul_next = {mul_sum, acc[XLEN-1:MUL_UNROLL]};

  // Restoring divide step; the partial remainder needs one extra bit after the shift
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;

  assign div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, mag_y};
  assign div_next = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, result;

  assign prod = (neg_x ^ neg_y) ? -acc : acc;
  assign quo  = (neg_x ^ neg_y) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = neg_x ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    if (bypass)
      result = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    else if (op_q[2])
      result = op_q[1] ? rem : quo;
    else if (op_q == 3'b000)
      result = prod[XLEN-1:0];
    else
      result = prod[2*XLEN-1:XLEN];
  end

  assign in_ready = (state == IDLE) && !flush;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      op_q      <= '0;
      neg_x     <= 1'b0;
      neg_y     <= 1'b0;
      bypass    <= 1'b0;
      mag_x     <= '0;
      mag_y     <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            neg_x  <= sx;
            neg_y  <= sy;
            mag_x  <= abs_x;
            mag_y  <= abs_y;
            bypass <= 1'b0;
            if (op[2]) begin
              // Bypass results are preloaded raw so FIXUP only selects a half
              if (div_zero) begin
                acc    <= {in_x, {XLEN{1'b1}}};
                bypass <= 1'b1;
                state  <= FIXUP;
              end else if (div_ovf) begin
                acc    <= {{XLEN{1'b0}}, in_x};
                bypass <= 1'b1;
                state  <= FIXUP;
              end else begin
                acc   <= {{XLEN{1'b0}}, abs_x};
                cnt   <= DIV_LAST;
                state <= DIV_EXEC;
              end
            end else begin
              acc   <= {{XLEN{1'b0}}, abs_y};
              cnt   <= MUL_LAST;
              state <= MUL_EXEC;
            end
          end
        end
        MUL_EXEC: begin
          acc <= mul_next;
          if (cnt == '0) state <= FIXUP;
          else           cnt   <= cnt - 1'b1;
        end
        DIV_EXEC: begin
          acc <= div_next;
          if (cnt == '0) state <= FIXUP;
          else           cnt   <= cnt - 1'b1;
        end
        FIXUP: begin
          out_data  <= result;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative (XLEN=32, MUL_UNROLL=4): directed vectors,
// latency checks, backpressure, flush and mid-operation reset.
module tb_mdu_iterative;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [2:0]  op;
  logic [31:0] in_x, in_y;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;

  mdu_iterative #(.XLEN(32), .MUL_UNROLL(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in_x(in_x), .in_y(in_y), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc_cyc;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops an expectation on every handshake; any result with nothing expected is an error
  logic prev_valid = 1'b0;
  int   rise_cyc = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (out_valid && !prev_valid) rise_cyc = cycle;
    prev_valid = out_valid;
    if (out_valid && sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL unexpected_result: got out_valid=1 data 0x%08h, required no result", out_data);
    end else if (out_valid && out_ready) begin
      mon_e = sb.pop_front();
      checkOutput($sformatf("data_r%0d", mon_e.tag), out_data, mon_e.data);
      checkOutput($sformatf("latency_r%0d", mon_e.tag), 32'(rise_cyc - mon_e.acc_cyc), 32'(mon_e.lat));
    end
  end

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] expd, input int lat, input int tag,
                               input bit drain);
    exp_t e;
    int   n;
    checkOutput($sformatf("in_ready_r%0d", tag), {31'b0, in_ready}, 32'd1);
    op = o; in_x = x; in_y = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op = 3'($urandom); in_x = $urandom; in_y = $urandom;
    e.data = expd; e.lat = lat; e.acc_cyc = cycle; e.tag = tag;
    sb.push_back(e);
    if (drain) begin
      n = 0;
      while (sb.size() != 0 && n < 200) begin
        tick();
        n++;
      end
      if (sb.size() != 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL timeout_r%0d: got no result in 200 cycles, required one", tag);
        sb.delete();
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = '0; in_x = '0; in_y = '0;
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out_data", out_data, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);

    applyStimulus(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9, 1, 1'b1);
    applyStimulus(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 2, 1'b1);
    applyStimulus(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, 3, 1'b1);
    applyStimulus(MUL,    32'd3,         32'd5,         32'd15,        9, 4, 1'b1);
    applyStimulus(MUL,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 9, 5, 1'b1);
    applyStimulus(MULH,   32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 9, 6, 1'b1);
    applyStimulus(MULHU,  32'hFFFF_FFFF, 32'd2,         32'd1,         9, 7, 1'b1);
    applyStimulus(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 8, 1'b1);
    applyStimulus(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 9, 1'b1);
    applyStimulus(DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF, 1, 10, 1'b1);
    applyStimulus(REMU,   32'd7,         32'd0,         32'd7,         1, 11, 1'b1);
    applyStimulus(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 12, 1'b1);
    applyStimulus(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 13, 1'b1);
    applyStimulus(DIVU,   32'd100,       32'd7,         32'd14,        33, 14, 1'b1);
    applyStimulus(REMU,   32'd100,       32'd7,         32'd2,         33, 15, 1'b1);
    applyStimulus(DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 16, 1'b1);
    applyStimulus(REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33, 17, 1'b1);
    applyStimulus(DIV,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1, 18, 1'b1);
    applyStimulus(REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1, 19, 1'b1);
    applyStimulus(DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 20, 1'b1);

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    applyStimulus(MUL, 32'd6, 32'd7, 32'd42, 9, 21, 1'b0);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold_data", out_data, 32'd42);
      checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("hold_release_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("hold_release_popped", 32'(sb.size()), 32'd0);
    tick();

    // Flush on cycle 10 of a divide: the result must never appear
    op = DIVU; in_x = 32'd100; in_y = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checkOutput("flush_busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_busy", {31'b0, busy}, 32'd0);
    checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 40; i++) tick();
    checkOutput("flush_busy_later", {31'b0, busy}, 32'd0);

    // Flush and a request together in IDLE: flush wins
    flush = 1'b1; in_valid = 1'b1; op = MUL; in_x = 32'd2; in_y = 32'd2;
    #1;
    checkOutput("flush_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_no_accept", {31'b0, busy}, 32'd0);
    tick();

    // Reset in the middle of a multiply
    op = MUL; in_x = 32'd3; in_y = 32'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_out_data", out_data, 32'd0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 15; i++) tick();
    applyStimulus(MUL, 32'd3, 32'd5, 32'd15, 9, 22, 1'b1);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mdu_iterative.md
MDU_ITERATIVE -- requirements
Module: mdu_iterative

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand/result width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter MUL_UNROLL, default 4, meaning multiplier bits consumed per multiply cycle; legal values are 1, 2, 4 and 8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: request present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: request can be accepted.
REQ-007 The block SHALL have port op, input, 3 bits: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 The block SHALL have ports in_x and in_y, input, XLEN bits each: rs1 and rs2.
REQ-009 The block SHALL have port flush, input, 1 bit: abort any operation in flight.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-012 The block SHALL have port out_data, output, XLEN bits: the result.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 The block SHALL implement states IDLE, MUL_EXEC, DIV_EXEC, FIXUP and DONE.
REQ-015 in_ready SHALL equal (state==IDLE && !flush); a request is accepted on a rising edge where in_valid && in_ready.
REQ-016 On acceptance, op, operand signs and operand magnitudes SHALL be latched; later changes to op, in_x and in_y SHALL have no effect on the operation.
REQ-017 Signedness: MUL/MULH/DIV/REM SHALL treat both operands as signed; MULHSU SHALL treat x as signed and y as unsigned; MULHU/DIVU/REMU SHALL treat both as unsigned.
REQ-018 Sign handling: iteration SHALL operate on unsigned magnitudes, and FIXUP SHALL negate the result as the operand signs require.
REQ-019 Multiply: MUL_EXEC SHALL run exactly XLEN/MUL_UNROLL cycles, shift-add of MUL_UNROLL bits per cycle into a 2*XLEN accumulator, then go to FIXUP.
REQ-020 Multiply result: MUL SHALL return product[XLEN-1:0]; MULH/MULHSU/MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-021 Divide: DIV_EXEC SHALL run exactly XLEN cycles, restoring radix-2 with one quotient bit per cycle, then go to FIXUP.
REQ-022 Quotient sign SHALL be sign(x) XOR sign(y); remainder sign SHALL be sign(x).
REQ-023 Divide by zero SHALL bypass iteration and go directly to FIXUP: quotient = all ones, remainder = x.
REQ-024 Signed overflow (DIV/REM, x = -2^(XLEN-1), y = -1) SHALL bypass iteration: quotient = x, remainder = 0.
REQ-025 FIXUP SHALL last one cycle, register out_data, and enter DONE.
REQ-026 Latency from the acceptance edge to the edge that sets out_valid SHALL be XLEN/MUL_UNROLL+1 cycles for multiplies, XLEN+1 for divides, and 1 for the bypass cases.
REQ-027 In DONE, out_valid=1 and out_data SHALL hold stable until an edge with out_ready=1; that edge SHALL clear out_valid and return to IDLE.
REQ-028 A new request SHALL NOT be accepted in the same cycle that a result is consumed (no back-to-back; minimum one IDLE cycle).
REQ-029 flush=1 in any state SHALL force IDLE on the next edge and clear out_valid; the discarded result is never presented.
REQ-030 If flush and in_valid are high together in IDLE, flush SHALL win and the request SHALL NOT be accepted.
REQ-031 The multiply datapath and the divide datapath SHALL share the accumulator and operand registers; only one operation is in flight at a time.

Reset
REQ-032 rst=1 on a rising edge SHALL set state=IDLE, out_valid=0, out_data=0, busy=0, and clear the accumulator and operand registers, from any state including mid-operation.
REQ-033 rst SHALL take priority over flush and in_valid.
REQ-034 After rst deasserts, in_ready SHALL be 1 in the first cycle, absent flush.

Verification
REQ-035 With XLEN=32 and MUL_UNROLL=4, a MULH request with x=0x80000000, y=0x80000000 and out_ready=1 SHALL give out_data=0x40000000 with out_valid set 9 edges after acceptance.
REQ-036 With XLEN=32, MULHSU x=0xFFFFFFFF (-1), y=0xFFFFFFFF SHALL give 0xFFFFFFFF, and MULHU with the same operands SHALL give 0xFFFFFFFE.
REQ-037 With XLEN=32, DIV x=-7, y=2 SHALL give 0xFFFFFFFD after 33 cycles; REM with the same operands SHALL give 0xFFFFFFFF; DIVU x=7, y=0 SHALL give 0xFFFFFFFF; REMU x=7, y=0 SHALL give 7 after 1 cycle.
REQ-038 With XLEN=32, DIV x=0x80000000, y=0xFFFFFFFF SHALL give 0x80000000, and REM with the same operands SHALL give 0; both SHALL have 1-cycle latency.
REQ-039 With out_ready held 0 for 5 cycles in DONE, out_data and out_valid SHALL stay stable, in_ready SHALL stay 0, and one transfer SHALL occur when out_ready rises.
REQ-040 Flush at cycle 10 of a divide SHALL make busy=0 on the next edge with no out_valid; rst mid-multiply SHALL give all outputs at reset values; a following MUL of 3 by 5 SHALL give 15.
